// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: flattened write ports, read ports and the conflict flag.
interface regfile_mp_if #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NREAD  = 4,
  parameter int unsigned NWRITE = 2
);
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NWRITE-1:0]        wr_en;
  logic [NWRITE*ADDR_W-1:0] wr_addr;
  logic [NWRITE*WIDTH-1:0]  wr_data;
  logic [NREAD-1:0]         rd_en;
  logic [NREAD*ADDR_W-1:0]  rd_addr;
  logic [NREAD*WIDTH-1:0]   rd_data;
  logic [NREAD-1:0]         rd_valid;
  logic                     wr_conflict;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, wr_conflict
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, wr_conflict
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads, highest-port-wins writes and a conflict flag.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NREAD    = 4,
  parameter int unsigned NWRITE   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_mp_if.slave rf
);
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0][WIDTH-1:0] mem_next;
  logic [ADDR_W-1:0]           wa      [NWRITE];
  logic [WIDTH-1:0]            wd      [NWRITE];
  logic [NWRITE-1:0]           wr_ok;
  logic [ADDR_W-1:0]           ra      [NREAD];
  logic [WIDTH-1:0]            rd_next [NREAD];
  logic [NREAD*WIDTH-1:0]      rd_data_q;
  logic [NREAD*WIDTH-1:0]      rd_data_next;
  logic [NREAD-1:0]            rd_valid_q;
  logic                        wr_conflict_q;
  logic                        conflict_c;

  // Address maps to real storage (and is not the hardwired zero register).
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < NWRITE; k++) begin
      wa[k]    = rf.wr_addr[k*ADDR_W +: ADDR_W];
      wd[k]    = rf.wr_data[k*WIDTH +: WIDTH];
      wr_ok[k] = rf.wr_en[k] && addr_ok(wa[k]);
    end
  end

  // Ascending port order lets the highest-index writer overwrite lower ones.
  always_comb begin
    mem_next = mem;
    for (int unsigned k = 0; k < NWRITE; k++) begin
      if (wr_ok[k]) mem_next[wa[k]] = wd[k];
    end
  end

  // Any enabled pair sharing an address collides, legal or not.
  always_comb begin
    conflict_c = 1'b0;
    for (int unsigned j = 0; j < NWRITE; j++) begin
      for (int unsigned k = j + 1; k < NWRITE; k++) begin
        if (rf.wr_en[j] && rf.wr_en[k] && (wa[j] == wa[k])) conflict_c = 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NREAD; i++) begin
      ra[i]      = rf.rd_addr[i*ADDR_W +: ADDR_W];
      rd_next[i] = '0;
      if (addr_ok(ra[i])) begin
        rd_next[i] = mem[ra[i]];
`ifdef REGFILE_BYPASS_EN
        for (int unsigned k = 0; k < NWRITE; k++) begin
          if (wr_ok[k] && (wa[k] == ra[i])) rd_next[i] = wd[k];
        end
`endif
      end
    end
  end

  always_comb begin
    rd_data_next = rd_data_q;
    for (int unsigned i = 0; i < NREAD; i++) begin
      if (rf.rd_en[i]) rd_data_next[i*WIDTH +: WIDTH] = rd_next[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem           <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      mem           <= mem_next;
      rd_data_q     <= rd_data_next;
      rd_valid_q    <= rf.rd_en;
      wr_conflict_q <= conflict_c;
    end
  end

  assign rf.rd_data     = rd_data_q;
  assign rf.rd_valid    = rd_valid_q;
  assign rf.wr_conflict = wr_conflict_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed vector bench for regfile_mp (DEPTH=24, 4 read / 2 write ports, ZERO_REG=1).
module tb_regfile_mp;
  localparam int unsigned WIDTH = 64;
  localparam int unsigned DEPTH = 24;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]   we;
    logic [9:0]   wa;
    logic [127:0] wd;
    logic [3:0]   re;
    logic [19:0]  ra;
    logic [255:0] ed;
    logic [3:0]   ev;
    logic         ec;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  vec_t vq[$];

  regfile_mp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(4), .NWRITE(2)) rf ();

  regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(4), .NWRITE(2), .ZERO_REG(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rf   (rf)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] d4(input logic [63:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [19:0] r4(input logic [4:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic add(input logic [1:0] we, input logic [4:0] wa1, wa0,
                     input logic [63:0] wd1, wd0, input logic [3:0] re,
                     input logic [19:0] ra, input logic [255:0] ed,
                     input logic [3:0] ev, input logic ec);
    vec_t v;
    v.we = we; v.wa = {wa1, wa0}; v.wd = {wd1, wd0};
    v.re = re; v.ra = ra; v.ed = ed; v.ev = ev; v.ec = ec;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] we, input logic [9:0] wa, input logic [127:0] wd,
                       input logic [3:0] re, input logic [19:0] ra);
    rf.wr_en = we; rf.wr_addr = wa; rf.wr_data = wd;
    rf.rd_en = re; rf.rd_addr = ra;
  endtask

  initial begin
    logic [63:0] r7v;
    r7v = BYP ? 64'h20 : 64'h10;

    rst_n = 1'b0;
    drive('0, '0, '0, '0, '0);
    #1;
    chk("reset rd_data", 256'(rf.rd_data), '0);
    chk("reset rd_valid", 256'(rf.rd_valid), '0);
    chk("reset wr_conflict", 256'(rf.wr_conflict), '0);
    @(negedge clk) rst_n = 1'b1;

    // we, wa1, wa0, wd1, wd0, re, ra, expected rd_data, rd_valid, wr_conflict
    add(2'b11, 5'd15, 5'd10, 64'h5A5A, 64'hA5A5, 4'b0000, '0, d4(0, 0, 0, 0), 4'b0000, 1'b0);
    add(2'b00, 5'd0, 5'd0, 0, 0, 4'b1111, r4(12, 4, 15, 10), d4(0, 0, 64'h5A5A, 64'hA5A5), 4'b1111, 1'b0);
    add(2'b11, 5'd2, 5'd2, 64'h2222, 64'h1111, 4'b0001, r4(0, 0, 0, 2),
        d4(0, 0, 64'h5A5A, BYP ? 64'h2222 : 64'h0), 4'b0001, 1'b1);
    add(2'b00, 5'd0, 5'd0, 0, 0, 4'b1000, r4(2, 0, 0, 0),
        d4(64'h2222, 0, 64'h5A5A, BYP ? 64'h2222 : 64'h0), 4'b1000, 1'b0);
    add(2'b01, 5'd0, 5'd0, 0, 64'hFFFF, 4'b0001, r4(0, 0, 0, 0), d4(64'h2222, 0, 64'h5A5A, 0), 4'b0001, 1'b0);
    add(2'b10, 5'd7, 5'd0, 64'h10, 0, 4'b0010, r4(0, 0, 0, 0), d4(64'h2222, 0, 0, 0), 4'b0010, 1'b0);
    add(2'b01, 5'd0, 5'd7, 0, 64'h20, 4'b0100, r4(0, 7, 0, 0), d4(64'h2222, r7v, 0, 0), 4'b0100, 1'b0);
    add(2'b00, 5'd0, 5'd0, 0, 0, 4'b0001, r4(0, 0, 0, 7), d4(64'h2222, r7v, 0, 64'h20), 4'b0001, 1'b0);
    for (int h = 0; h < 3; h++)
      add(2'b00, 5'd0, 5'd0, 0, 0, 4'b0000, r4(7, 7, 7, 7), d4(64'h2222, r7v, 0, 64'h20), 4'b0000, 1'b0);
    add(2'b11, 5'd30, 5'd5, 64'hDEAD, 64'h55, 4'b1000, r4(30, 0, 0, 0), d4(0, r7v, 0, 64'h20), 4'b1000, 1'b0);
    add(2'b00, 5'd0, 5'd0, 0, 0, 4'b1111, r4(6, 23, 5, 30), d4(0, 0, 64'h55, 0), 4'b1111, 1'b0);
    add(2'b11, 5'd28, 5'd28, 64'h2, 64'h1, 4'b0000, '0, d4(0, 0, 64'h55, 0), 4'b0000, 1'b1);
    add(2'b11, 5'd4, 5'd3, 64'h4, 64'h3, 4'b0001, r4(0, 0, 0, 3),
        d4(0, 0, 64'h55, BYP ? 64'h3 : 64'h0), 4'b0001, 1'b0);
    add(2'b00, 5'd0, 5'd0, 0, 0, 4'b1100, r4(4, 3, 0, 0),
        d4(64'h4, 64'h3, 64'h55, BYP ? 64'h3 : 64'h0), 4'b1100, 1'b0);

    for (int n = 0; n < vq.size(); n++) begin
      @(negedge clk);
      drive(vq[n].we, vq[n].wa, vq[n].wd, vq[n].re, vq[n].ra);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rd_data", n), 256'(rf.rd_data), vq[n].ed);
      chk($sformatf("v%0d rd_valid", n), 256'(rf.rd_valid), 256'(vq[n].ev));
      chk($sformatf("v%0d wr_conflict", n), 256'(rf.wr_conflict), 256'(vq[n].ec));
    end

    // Reset in the middle of a cycle with a read result on the outputs.
    @(negedge clk);
    drive(2'b01, {5'd0, 5'd5}, {64'h0, 64'h1234}, 4'b0000, '0);
    @(negedge clk);
    drive(2'b00, '0, '0, 4'b0001, r4(0, 0, 0, 5));
    @(posedge clk);
    #1;
    chk("pre-reset r5", 256'(rf.rd_data), d4(64'h4, 64'h3, 64'h55, 64'h1234));
    chk("pre-reset valid", 256'(rf.rd_valid), 256'(4'b0001));
    #2;
    rst_n = 1'b0;
    drive(2'b01, {5'd0, 5'd6}, {64'h0, 64'h66}, 4'b0001, r4(0, 0, 0, 5));
    #1;
    chk("async reset rd_data", 256'(rf.rd_data), '0);
    chk("async reset rd_valid", 256'(rf.rd_valid), '0);
    @(posedge clk);
    #1;
    chk("valid held low in reset", 256'(rf.rd_valid), '0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b01, {5'd0, 5'd9}, {64'h0, 64'h99}, 4'b0011, r4(0, 0, 6, 5));
    @(posedge clk);
    #1;
    chk("post-reset r5/r6", 256'(rf.rd_data), '0);
    chk("post-reset valid", 256'(rf.rd_valid), 256'(4'b0011));
    @(negedge clk);
    drive(2'b00, '0, '0, 4'b0100, r4(0, 9, 0, 0));
    @(posedge clk);
    #1;
    chk("first write after reset", 256'(rf.rd_data), d4(0, 64'h99, 0, 0));
    chk("first write valid", 256'(rf.rd_valid), 256'(4'b0100));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, the next generation of the single-cycle processor's 4-read/2-write 64-bit register file. It generalises width, depth and port counts, and adds asynchronous reset, registered reads with valid flags, and deterministic write-conflict resolution with a conflict flag. An optional write-to-read bypass is available. It sits between decode (read addresses) and writeback (write ports) in the datapath.

## Interface
- `WIDTH`, 64: data width in bits.
- `DEPTH`, 32: number of registers; `ADDR_W = $clog2(DEPTH)`.
- `NREAD`, 4: number of read ports, 1..8.
- `NWRITE`, 2: number of write ports, 1..4.
- `ZERO_REG`, 1: if 1, register 0 reads as 0 and ignores writes.

Ports:
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `wr_en` input NWRITE: per-port write enable.
- `wr_addr` input NWRITE*ADDR_W: flattened write addresses; port k is at `[k*ADDR_W +: ADDR_W]`.
- `wr_data` input NWRITE*WIDTH: flattened write data.
- `rd_en` input NREAD: per-port read enable.
- `rd_addr` input NREAD*ADDR_W: flattened read addresses.
- `rd_data` output NREAD*WIDTH: flattened registered read data.
- `rd_valid` output NREAD: high the cycle after a read was accepted.
- `wr_conflict` output 1: registered flag; pulses when two or more enabled write ports hit the same address in one cycle.

## Operation
- **Reset** (`rst_n`=0, immediate, no clock needed):
  - all DEPTH registers clear to 0;
  - `rd_data`, `rd_valid` and `wr_conflict` clear to 0.
- **Write, per edge:**
  - Each port k with `wr_en[k]`=1 and a legal address writes `wr_data[k]`.
  - Legal address: `< DEPTH`, and not 0 when `ZERO_REG`=1.
  - If several enabled ports share an address, the highest-index port wins; lower ports to that address are dropped.
- **wr_conflict:**
  - Set for one cycle after any same-address collision among enabled ports.
  - Collisions on illegal addresses also count.
- **Read, per edge, port i:**
  - If `rd_en[i]`=1: `rd_data[i]` loads the register at `rd_addr[i]`, and `rd_valid[i]` goes to 1.
  - Otherwise `rd_data[i]` holds its last value and `rd_valid[i]` goes to 0.
- **Read returns 0 when:**
  - the address is `>= DEPTH`, or
  - the address is 0 and `ZERO_REG`=1.
- **Same-edge read and write to one address:** read returns the pre-write value, unless bypass is compiled in (see Configuration).
- Read ports are fully independent: any number may address the same register.
- All NWRITE writes and NREAD reads complete in a single cycle; there is no stall and no backpressure.

## Timing
- Write latency: 1 edge; the new value is visible to a read issued on the next edge.
- Read latency: 1 edge from `rd_en`/`rd_addr` sampled to `rd_data`/`rd_valid`.
- `wr_conflict` latency: 1 edge.
- **Reset mid-operation:**
  - in-flight writes on the asserting edge are lost;
  - outputs go to 0 asynchronously;
  - the first write is accepted on the first rising edge after `rst_n` deasserts.
- `rd_valid` never asserts while `rst_n`=0.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- **Defined:** a read on the same edge as a legal write to the same address returns the winning (highest-index) write data. Reads of address 0 with `ZERO_REG`=1 still return 0.
- **Undefined:** such reads return the old stored value; no forwarding logic is built.

## Test plan
- **Reset:** write 0x1234 to r5, assert `rst_n`=0 mid-cycle, release, read r5 -> `rd_data` is 0 immediately on assert; read returns 0 and `rd_valid`=1 the next cycle.
- **Dual write, quad read:**
  - Edge 1: write r10=0xA5A5 (port 0) and r15=0x5A5A (port 1).
  - Edge 2: read r10, r15, r4, r12.
  - Response: 0xA5A5, 0x5A5A, 0, 0 with `rd_valid`=4'b1111.
- **Write conflict:** both ports write r2, port 0 = 0x1111, port 1 = 0x2222 -> `wr_conflict`=1 for one cycle; a later read of r2 returns 0x2222.
- **Zero register:** `ZERO_REG`=1, write 0xFFFF to r0 -> read r0 returns 0; `wr_conflict` stays 0 for a single-port write.
- **Same-edge read/write:** r7 holds 0x10, then on one edge write r7=0x20 and read r7:
  - response 0x10 without `REGFILE_BYPASS_EN`;
  - response 0x20 with it.
- **Hold and out of range:**
  - `rd_en`=0 for 3 cycles -> `rd_data` held and `rd_valid`=0.
  - With DEPTH=24, read address 30 -> 0; write address 30 is ignored.
